// File: rtl/instmem_pkg.sv
// Shared constants, loader state encoding and small helpers for the instruction-memory loader.
package instmem_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_COUNT = S_COUNT,
        ST_HI    = S_HI,
        ST_LO    = S_LO,
        ST_WRITE = S_WRITE,
        ST_CSUM  = S_CSUM,
        ST_DONE  = S_DONE,
        ST_ERR   = S_ERR
    } loader_state_t;

    // Running XOR checksum over the data bytes of an image.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // A word count is usable when it is non-zero and fits in the memory.
    function automatic logic count_ok(input logic [7:0] count, input logic [7:0] depth);
        return (count != 8'd0) && (count <= depth);
    endfunction

endpackage

// File: rtl/instmem_loader.sv
// Byte-stream loader for the 64x16 instruction memory; holds the CPU until an image is in.
// Optional trailing checksum byte enabled by defining INSTMEM_LOADER_CHECKSUM_EN.
module instmem_loader
    import instmem_pkg::*;
#(
    parameter int ADDR_W = instmem_pkg::ADDR_W,
    parameter int DATA_W = instmem_pkg::DATA_W,
    parameter int DEPTH  = instmem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    loader_state_t     state_r;
    loader_state_t     state_next_s;
    logic [ADDR_W:0]   n_r;
    logic [ADDR_W:0]   n_next_s;
    logic [ADDR_W:0]   words_r;
    logic [ADDR_W:0]   words_next_s;
    logic [7:0]        hi_r;
    logic [7:0]        hi_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] wdata_next_s;
    logic              ready_r;
    logic              ready_next_s;
    logic              we_r;
    logic              we_next_s;
    logic              hold_r;
    logic              hold_next_s;
    logic              done_r;
    logic              done_next_s;
    logic              err_r;
    logic              err_next_s;
    logic              accept_s;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_r;
    logic [7:0]        csum_next_s;
`endif

    assign accept_s = byte_valid & ready_r;

    // Next-state and datapath update for the load session.
    always_comb begin
        state_next_s = state_r;
        n_next_s     = n_r;
        words_next_s = words_r;
        hi_next_s    = hi_r;
        addr_next_s  = addr_r;
        wdata_next_s = wdata_r;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
        csum_next_s  = csum_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next_s = ST_COUNT;
                    addr_next_s  = '0;
                    words_next_s = '0;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                    csum_next_s  = 8'h00;
`endif
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_COUNT: begin
                if (accept_s) begin
                    if (count_ok(byte_data, 8'(DEPTH))) begin
                        n_next_s     = byte_data[ADDR_W:0];
                        state_next_s = ST_HI;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = ST_COUNT;
                end
            end
            ST_HI: begin
                if (accept_s) begin
                    hi_next_s    = byte_data;
                    state_next_s = ST_LO;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                    csum_next_s  = csum_update(csum_r, byte_data);
`endif
                end else begin
                    state_next_s = ST_HI;
                end
            end
            ST_LO: begin
                if (accept_s) begin
                    wdata_next_s = {hi_r, byte_data};
                    state_next_s = ST_WRITE;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                    csum_next_s  = csum_update(csum_r, byte_data);
`endif
                end else begin
                    state_next_s = ST_LO;
                end
            end
            ST_WRITE: begin
                words_next_s = words_r + {{ADDR_W{1'b0}}, 1'b1};
                // The address only advances when another word follows, so it never wraps.
                if (words_next_s == n_r) begin
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                    state_next_s = ST_CSUM;
`else
                    state_next_s = ST_DONE;
`endif
                end else begin
                    addr_next_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_next_s = ST_HI;
                end
            end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_s) begin
                    if (byte_data == csum_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = ST_CSUM;
                end
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so every output leaves a flop.
    always_comb begin
        ready_next_s = 1'b0;
        we_next_s    = 1'b0;
        hold_next_s  = 1'b1;
        done_next_s  = 1'b0;
        err_next_s   = 1'b0;
        case (state_next_s)
            ST_COUNT, ST_HI, ST_LO, ST_CSUM: begin
                ready_next_s = 1'b1;
            end
            ST_WRITE: begin
                we_next_s = 1'b1;
            end
            ST_DONE: begin
                hold_next_s = 1'b0;
                done_next_s = 1'b1;
            end
            ST_ERR: begin
                err_next_s = 1'b1;
            end
            default: begin
                ready_next_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            n_r     <= '0;
            words_r <= '0;
            hi_r    <= 8'h00;
            addr_r  <= '0;
            wdata_r <= '0;
            ready_r <= 1'b0;
            we_r    <= 1'b0;
            hold_r  <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            n_r     <= n_next_s;
            words_r <= words_next_s;
            hi_r    <= hi_next_s;
            addr_r  <= addr_next_s;
            wdata_r <= wdata_next_s;
            ready_r <= ready_next_s;
            we_r    <= we_next_s;
            hold_r  <= hold_next_s;
            done_r  <= done_next_s;
            err_r   <= err_next_s;
        end
    end

`ifdef INSTMEM_LOADER_CHECKSUM_EN
    // Checksum accumulator over the data bytes of the current image.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_r <= 8'h00;
        end else begin
            csum_r <= csum_next_s;
        end
    end
`endif

    assign byte_ready = ready_r;
    assign mem_we     = we_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign cpu_hold   = hold_r;
    assign load_done  = done_r;
    assign load_err   = err_r;

endmodule

// File: tb/tb_instmem_loader.sv
// Self-checking bench for instmem_loader: directed and random images against a byte-stream model.
module tb_instmem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  img[$];
    logic [5:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic        prev_we = 1'b0;

    instmem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture every memory write; a strobe must be a single cycle with the stream stalled.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            chk("we_single_cycle", 32'(prev_we), 32'd0);
            chk("ready_low_in_write", 32'(byte_ready), 32'd0);
        end
        prev_we <= mem_we;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_session();
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        chk("start_clears_done", 32'(load_done), 32'd0);
        chk("start_clears_err", 32'(load_err), 32'd0);
        chk("start_holds_cpu", 32'(cpu_hold), 32'd1);
        chk("start_ready", 32'(byte_ready), 32'd1);
        chk("start_addr0", 32'(mem_addr), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        int t;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = $urandom_range(0, 255);
    endtask

    function automatic logic [7:0] img_xor(input int nwords);
        logic [7:0] x = 8'h00;
        for (int i = 1; i <= 2 * nwords; i++) x = x ^ img[i];
        return x;
    endfunction

    // Build a well-formed image of n random words (with its checksum when enabled).
    task automatic build_random(input int n);
        img.delete();
        img.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) img.push_back(8'($urandom_range(0, 255)));
`ifdef INSTMEM_LOADER_CHECKSUM_EN
        img.push_back(img_xor(n));
`endif
    endtask

    task automatic send_from(input int first, input int maxgap);
        for (int i = first; i < img.size(); i++) send_byte(img[i], maxgap);
    endtask

    // Wait for the session to settle, then compare against the image's expected outcome.
    task automatic finish_check(input string tag);
        int n;
        int nw;
        logic exp_err;
        int t;
        n = int'(img[0]);
        if (n == 0 || n > 64) begin
            exp_err = 1'b1;
            nw = 0;
        end else begin
            nw = n;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
            exp_err = (img[2 * n + 1] != img_xor(n));
`else
            exp_err = 1'b0;
`endif
        end
        t = 0;
        while (load_done !== 1'b1 && load_err !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_settle_timeout"}, 32'(t < 20), 32'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_write_count"}, 32'(wr_addr_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            chk({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
            chk({tag, "_data"}, 32'(wr_data_q[i]), 32'({img[1 + 2 * i], img[2 + 2 * i]}));
        end
        chk({tag, "_done"}, 32'(load_done), 32'(!exp_err));
        chk({tag, "_err"}, 32'(load_err), 32'(exp_err));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(exp_err));
        chk({tag, "_ready_idle"}, 32'(byte_ready), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Two-word directed image; a start pulse mid-session must be ignored.
        img = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef INSTMEM_LOADER_CHECKSUM_EN
        img.push_back(8'h40);
`endif
        begin_session();
        send_byte(img[0], 0);
        pulse_start();
        chk("mid_start_ready", 32'(byte_ready), 32'd1);
        send_from(1, 0);
        finish_check("two_words");

        // Full 64-word image with random stalls: addresses 0..63, no wrap.
        build_random(64);
        begin_session();
        send_from(0, 3);
        finish_check("full64");

        // Random sizes, including the single-word boundary.
        build_random(1);
        begin_session();
        send_from(0, 2);
        finish_check("one_word");
        for (int k = 0; k < 3; k++) begin
            build_random(int'($urandom_range(2, 63)));
            begin_session();
            send_from(0, 2);
            finish_check("rand_n");
        end

        // Out-of-range counts.
        img = '{8'h00};
        begin_session();
        send_from(0, 0);
        finish_check("count_zero");
        img = '{8'h41};
        begin_session();
        send_from(0, 1);
        finish_check("count_65");

`ifdef INSTMEM_LOADER_CHECKSUM_EN
        // Bad checksum: the word stays written but the image is rejected.
        img = '{8'h01, 8'hAA, 8'h55, 8'h00};
        begin_session();
        send_from(0, 0);
        finish_check("bad_csum");
`endif

        // Reset while waiting for the hi byte of word 3, then a clean reload.
        build_random(5);
        begin_session();
        for (int i = 0; i < 7; i++) send_byte(img[i], 1);
        @(negedge clk);
        chk("abort_writes", 32'(wr_addr_q.size()), 32'd3);
        chk("abort_in_hi", 32'(byte_ready), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_hold", 32'(cpu_hold), 32'd1);
        chk("abort_ready", 32'(byte_ready), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_flags", 32'({load_done, load_err}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        build_random(4);
        begin_session();
        send_from(0, 2);
        finish_check("reload");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
